// File: rtl/bit_scan_driver.sv
// rtl/bit_scan_driver.sv - time-multiplexed single-bit digit scan driver with double-buffered word
module bit_scan_driver #(
    parameter int WIDTH = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    output logic             onebit,
    output logic [WIDTH-1:0] digit_en,
    output logic             pending,
    output logic             frame_done
);
    localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
    localparam int IW   = $clog2(WIDTH);
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST   = IW'(WIDTH - 1);
    localparam bit            HAS_GAP    = (BLANK > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] shadow;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;

    logic             show_end;
    logic             gap_end;
    logic             advance;
    logic             boundary;
    logic [IW-1:0]    next_idx;
    logic [WIDTH-1:0] next_active;

    always_comb begin
        show_end    = (state == SHOW) && (cnt == DIV_LAST);
        gap_end     = (state == GAP) && (cnt == BLANK_LAST);
        advance     = (show_end && !HAS_GAP) || gap_end;
        boundary    = advance && (idx == IDX_LAST);
        next_idx    = boundary ? '0 : idx + 1'b1;
        next_active = active;
        // A load on the boundary edge itself beats any older shadow word.
        if (boundary) begin
            if (load)
                next_active = data_in;
            else if (pending)
                next_active = shadow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            active     <= '0;
            shadow     <= '0;
            idx        <= '0;
            cnt        <= '0;
            onebit     <= 1'b0;
            digit_en   <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (clear) begin
                state    <= IDLE;
                active   <= '0;
                shadow   <= '0;
                idx      <= '0;
                cnt      <= '0;
                onebit   <= 1'b0;
                digit_en <= '0;
                pending  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            state    <= SHOW;
                            active   <= data_in;
                            idx      <= '0;
                            cnt      <= '0;
                            digit_en <= WIDTH'(1);
                            onebit   <= data_in[0];
                            pending  <= 1'b0;
                        end
                    end
                    SHOW, GAP: begin
                        if (advance) begin
                            // Direct one-hot to one-hot handoff: never two digits lit.
                            state    <= SHOW;
                            idx      <= next_idx;
                            cnt      <= '0;
                            active   <= next_active;
                            digit_en <= WIDTH'(1) << next_idx;
                            onebit   <= next_active[next_idx];
                            if (boundary) begin
                                frame_done <= 1'b1;
                                pending    <= 1'b0;
                            end
                        end else if (show_end) begin
                            state    <= GAP;
                            cnt      <= '0;
                            digit_en <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                        if (load && !boundary) begin
                            shadow  <= data_in;
                            pending <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        digit_en <= '0;
                        onebit   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
